// File: rtl/bri_qq_drive.sv
// H-bridge / Q-damping switch sequencer: one transmit burst per start pulse,
// with burst parameters snapshotted at start and every output registered.
module bri_qq_drive #(
  parameter int unsigned CYC_W = 8
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CYC_W-1:0] cycle_num,
  input  logic [7:0]       half_para,
  input  logic [3:0]       qq_para1,
  input  logic [5:0]       qq_para2,
  input  logic [5:0]       qq_para3,
  output logic             bri_a,
  output logic             bri_b,
  output logic             qq_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, PH_A, DEAD_A, PH_B, DEAD_B, QQ_DLY, QQ_ON, DONE
  } state_t;

  state_t           state_q, state_d, nxt;
  logic             launch_q, launch_d, adv;
  logic [7:0]       cnt_q, cnt_d;
  logic [CYC_W-1:0] per_q, per_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [7:0]       half_q, half_d;
  logic [3:0]       qq1_q, qq1_d;
  logic [5:0]       qq2_q, qq2_d, qq3_q, qq3_d;
  logic             bri_a_q, bri_b_q, qq_en_q, busy_q, done_q;
  state_t           after_qdly, after_bri, after_per;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    launch_d = 1'b0;
    cyc_d    = cyc_q;
    half_d   = half_q;
    qq1_d    = qq1_q;
    qq2_d    = qq2_q;
    qq3_d    = qq3_q;
    adv      = 1'b0;
    nxt      = IDLE;

    // zero-length stages are skipped by choosing the next non-empty successor
    after_qdly = (qq3_q != '0) ? QQ_ON : DONE;
    after_bri  = (qq2_q != '0) ? QQ_DLY : after_qdly;
    after_per  = (per_q > CYC_W'(1)) ? PH_A : after_bri;

    unique case (state_q)
      IDLE: begin
        if (launch_q) begin
          adv   = 1'b1;
          per_d = cyc_q;
          nxt   = (cyc_q != '0 && half_q != '0) ? PH_A : after_bri;
        end
      end
      PH_A:   if (cnt_q == 8'd1) begin adv = 1'b1; nxt = (qq1_q != '0) ? DEAD_A : PH_B; end
      DEAD_A: if (cnt_q == 8'd1) begin adv = 1'b1; nxt = PH_B; end
      PH_B: begin
        if (cnt_q == 8'd1) begin
          adv = 1'b1;
          nxt = (qq1_q != '0) ? DEAD_B : after_per;
          if (qq1_q == '0) per_d = per_q - CYC_W'(1);
        end
      end
      DEAD_B: if (cnt_q == 8'd1) begin adv = 1'b1; nxt = after_per; per_d = per_q - CYC_W'(1); end
      QQ_DLY: if (cnt_q == 8'd1) begin adv = 1'b1; nxt = after_qdly; end
      QQ_ON:  if (cnt_q == 8'd1) begin adv = 1'b1; nxt = DONE; end
      DONE:   begin adv = 1'b1; nxt = IDLE; end
      default: begin adv = 1'b1; nxt = IDLE; end
    endcase

    if (adv) begin
      state_d = nxt;
      unique case (nxt)
        PH_A, PH_B:     cnt_d = half_q;
        DEAD_A, DEAD_B: cnt_d = {4'b0, qq1_q};
        QQ_DLY:         cnt_d = {2'b0, qq2_q};
        QQ_ON:          cnt_d = {2'b0, qq3_q};
        default:        cnt_d = '0;
      endcase
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - 8'd1;
    end

    if (state_q == IDLE && !launch_q && start) begin
      launch_d = 1'b1;
      cyc_d    = cycle_num;
      half_d   = half_para;
      qq1_d    = qq_para1;
      qq2_d    = qq_para2;
      qq3_d    = qq_para3;
    end

    if (abort) begin
      state_d  = IDLE;
      launch_d = 1'b0;
      cnt_d    = '0;
      per_d    = '0;
      cyc_d    = cyc_q;
      half_d   = half_q;
      qq1_d    = qq1_q;
      qq2_d    = qq2_q;
      qq3_d    = qq3_q;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
      cnt_q    <= '0;
      per_q    <= '0;
      cyc_q    <= '0;
      half_q   <= '0;
      qq1_q    <= '0;
      qq2_q    <= '0;
      qq3_q    <= '0;
      bri_a_q  <= 1'b0;
      bri_b_q  <= 1'b0;
      qq_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      cyc_q    <= cyc_d;
      half_q   <= half_d;
      qq1_q    <= qq1_d;
      qq2_q    <= qq2_d;
      qq3_q    <= qq3_d;
      bri_a_q  <= (state_d == PH_A);
      bri_b_q  <= (state_d == PH_B);
      qq_en_q  <= (state_d == QQ_ON);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign bri_a = bri_a_q;
  assign bri_b = bri_b_q;
  assign qq_en = qq_en_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bri_qq_drive.sv
// Self-checking bench for bri_qq_drive: directed bursts plus random bursts
// compared cycle by cycle against an expected-waveform queue.
module tb_bri_qq_drive;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cycle_num = '0;
  logic [7:0] half_para = '0;
  logic [3:0] qq_para1 = '0;
  logic [5:0] qq_para2 = '0;
  logic [5:0] qq_para3 = '0;
  logic       bri_a, bri_b, qq_en, busy, done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [4:0]  exp_q[$];

  // {bri_a, bri_b, qq_en, busy, done}
  localparam logic [4:0] W_IDLE = 5'b00000;
  localparam logic [4:0] W_A    = 5'b10010;
  localparam logic [4:0] W_B    = 5'b01010;
  localparam logic [4:0] W_Q    = 5'b00110;
  localparam logic [4:0] W_BUSY = 5'b00010;
  localparam logic [4:0] W_DONE = 5'b00011;

  bri_qq_drive #(.CYC_W(8)) dut (
    .clk_sys(clk_sys), .rst(rst), .start(start), .abort(abort),
    .cycle_num(cycle_num), .half_para(half_para), .qq_para1(qq_para1),
    .qq_para2(qq_para2), .qq_para3(qq_para3),
    .bri_a(bri_a), .bri_b(bri_b), .qq_en(qq_en), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] outs();
    return {bri_a, bri_b, qq_en, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Expected waveform: index 0 is the cycle right after the start edge,
  // the last entry is the idle cycle after done.
  function automatic void build(input int c, input int h, input int d, input int q2, input int q3);
    exp_q.delete();
    exp_q.push_back(W_IDLE);
    if (c != 0 && h != 0)
      for (int p = 0; p < c; p++) begin
        for (int i = 0; i < h; i++) exp_q.push_back(W_A);
        for (int i = 0; i < d; i++) exp_q.push_back(W_BUSY);
        for (int i = 0; i < h; i++) exp_q.push_back(W_B);
        for (int i = 0; i < d; i++) exp_q.push_back(W_BUSY);
      end
    for (int i = 0; i < q2; i++) exp_q.push_back(W_BUSY);
    for (int i = 0; i < q3; i++) exp_q.push_back(W_Q);
    exp_q.push_back(W_DONE);
    exp_q.push_back(W_IDLE);
  endfunction

  task automatic launch(input int c, input int h, input int d, input int q2, input int q3);
    cycle_num = 8'(c);
    half_para = 8'(h);
    qq_para1  = 4'(d);
    qq_para2  = 6'(q2);
    qq_para3  = 6'(q3);
    start     = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  // Runs a full burst from a negedge; optionally pokes half_para/start at one cycle.
  task automatic run_burst(input string tag, input int c, input int h, input int d,
                           input int q2, input int q3, input int poke_cyc,
                           input int poke_half, input logic poke_start);
    build(c, h, d, q2, q3);
    launch(c, h, d, q2, q3);
    for (int n = 0; n < exp_q.size(); n++) begin
      if (n > 0) begin
        @(negedge clk_sys);
        start = 1'b0;
      end
      chk($sformatf("%s c%0d", tag, n), outs(), exp_q[n]);
      if (poke_cyc != 0 && n == poke_cyc) begin
        half_para = 8'(poke_half);
        start     = poke_start;
      end
    end
  endtask

  initial begin
    int c, h, d, q2, q3;
    #3;
    chk("reset", outs(), W_IDLE);
    @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("idle_after_reset", outs(), W_IDLE);

    run_burst("t1", 2, 3, 1, 2, 4, 0, 0, 1'b0);
    run_burst("t2_snapshot", 2, 3, 1, 2, 4, 5, 9, 1'b0);
    run_burst("t3_zero_dead", 1, 2, 0, 0, 0, 0, 0, 1'b0);
    run_burst("t4_no_bridge", 0, 3, 1, 3, 2, 0, 0, 1'b0);
    run_burst("all_zero", 0, 0, 0, 0, 0, 0, 0, 1'b0);

    // abort during the first PH_B, then a clean restart
    build(2, 3, 1, 2, 4);
    launch(2, 3, 1, 2, 4);
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) @(negedge clk_sys);
      chk($sformatf("t5 c%0d", n), outs(), exp_q[n]);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    start = 1'b0;
    chk("t5_abort c7", outs(), W_IDLE);
    for (int n = 8; n <= 9; n++) begin
      @(negedge clk_sys);
      chk($sformatf("t5_abort c%0d", n), outs(), W_IDLE);
    end
    run_burst("t5_restart", 2, 3, 1, 2, 4, 0, 0, 1'b0);

    // asynchronous reset during QQ_ON
    build(2, 3, 1, 2, 4);
    launch(2, 3, 1, 2, 4);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_sys);
      chk($sformatf("t6 c%0d", n), outs(), exp_q[n]);
    end
    #2 rst = 1'b1;
    #1 chk("t6_async_rst", outs(), W_IDLE);
    #1 rst = 1'b0;
    @(negedge clk_sys);
    chk("t6_after_rst", outs(), W_IDLE);
    run_burst("t6_start_busy", 2, 3, 1, 2, 4, 8, 3, 1'b1);

    for (int r = 0; r < 8; r++) begin
      c  = int'($urandom_range(0, 3));
      h  = int'($urandom_range(1, 6));
      d  = int'($urandom_range(0, 3));
      q2 = int'($urandom_range(0, 5));
      q3 = int'($urandom_range(0, 5));
      run_burst($sformatf("rnd%0d", r), c, h, d, q2, q3, 0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
